// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with the load-use hazard detector folded in.
// Captures the decode control word and operands and presents them to EX one cycle later.
// A bubble is loaded on a load-use hazard or an upstream flush. Flush wins over hazard.
// Optional build macro: ID_EX_STALL_CNT_EN adds a saturating 16-bit stall counter (stall_cnt).
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_alu_src,
    input  logic [5:0]        id_funct,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    output logic              ex_reg_dst,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic [5:0]        ex_funct,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic              ex_valid,
    output logic              stall
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    // Registered EX-side control word
    logic              r_reg_dst;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;
    logic              r_alu_src;
    logic [5:0]        r_funct;
    logic              r_valid;

    // Registered EX-side specifiers and data
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc4;

    // Hazard detection terms
    logic w_uses_rt;
    logic w_rt_nonzero;
    logic w_rs_match;
    logic w_rt_match;
    logic w_hazard;
    logic w_bubble;

    // Load-use hazard: EX holds a load whose destination rt is read by the decode instruction
    always_comb begin
        // R-type and stores read rt; I-type ALU ops and loads only read rs
        w_uses_rt    = id_reg_dst | id_mem_write;
        w_rt_nonzero = (r_rt != '0);
        w_rs_match   = (r_rt == id_rs);
        w_rt_match   = w_uses_rt & (r_rt == id_rt);
        w_hazard     = r_mem_read & w_rt_nonzero & (w_rs_match | w_rt_match);
        // A flushed instruction is squashed, so holding it upstream would be pointless
        stall        = w_hazard & ~flush;
        w_bubble     = w_hazard | flush;
    end

    // Control word: a bubble zeroes the controls so it cannot write state or re-trigger a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_dst    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_src    <= 1'b0;
            r_funct      <= 6'd0;
            r_valid      <= 1'b0;
        end else if (w_bubble) begin
            r_reg_dst    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_src    <= 1'b0;
            r_funct      <= 6'd0;
            r_valid      <= 1'b0;
        end else begin
            r_reg_dst    <= id_reg_dst;
            r_reg_write  <= id_reg_write;
            r_mem_read   <= id_mem_read;
            r_mem_write  <= id_mem_write;
            r_mem_to_reg <= id_mem_to_reg;
            r_alu_src    <= id_alu_src;
            r_funct      <= id_funct;
            r_valid      <= 1'b1;
        end
    end

    // Specifiers and data load every cycle, bubble or not, so EX contents stay deterministic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs  <= '0;
            r_rt  <= '0;
            r_rd  <= '0;
            r_rd1 <= '0;
            r_rd2 <= '0;
            r_imm <= '0;
            r_pc4 <= '0;
        end else begin
            r_rs  <= id_rs;
            r_rt  <= id_rt;
            r_rd  <= id_rd;
            r_rd1 <= id_rd1;
            r_rd2 <= id_rd2;
            r_imm <= id_imm;
            r_pc4 <= id_pc4;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Count stalled cycles, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign ex_reg_dst    = r_reg_dst;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_mem_to_reg = r_mem_to_reg;
    assign ex_alu_src    = r_alu_src;
    assign ex_funct      = r_funct;
    assign ex_rs         = r_rs;
    assign ex_rt         = r_rt;
    assign ex_rd         = r_rd;
    assign ex_rd1        = r_rd1;
    assign ex_rd2        = r_rd2;
    assign ex_imm        = r_imm;
    assign ex_pc4        = r_pc4;
    assign ex_valid      = r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expectations, a negedge monitor checks them.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
    logic [5:0]    id_funct;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rd1, id_rd2, id_imm, id_pc4;
    logic          ex_reg_dst, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
    logic [5:0]    ex_funct;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [DW-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
    logic          ex_valid;
    logic          stall;
`ifdef ID_EX_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    typedef struct packed {
        logic          reg_dst;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic          alu_src;
        logic [5:0]    funct;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc4;
    } instr_t;

    typedef struct packed {
        instr_t f;
        logic   valid;
    } ex_t;

    typedef struct {
        ex_t         ex;
        logic [15:0] cnt;
    } exp_t;

    // Control words {reg_dst, reg_write, mem_read, mem_write, mem_to_reg, alu_src}
    localparam logic [5:0] CPass = 6'b110010;
    localparam logic [5:0] CR    = 6'b110000;
    localparam logic [5:0] CLw   = 6'b011011;
    localparam logic [5:0] CAddi = 6'b010001;
    localparam logic [5:0] CSw   = 6'b000101;

    exp_t        q_ex[$];
    logic        q_stall[$];
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    ex_t         m_ex;
    int unsigned m_cnt;
    logic        last_stall;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .id_reg_dst    (id_reg_dst),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .id_mem_write  (id_mem_write),
        .id_mem_to_reg (id_mem_to_reg),
        .id_alu_src    (id_alu_src),
        .id_funct      (id_funct),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .id_rd1        (id_rd1),
        .id_rd2        (id_rd2),
        .id_imm        (id_imm),
        .id_pc4        (id_pc4),
        .ex_reg_dst    (ex_reg_dst),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_alu_src    (ex_alu_src),
        .ex_funct      (ex_funct),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_rd         (ex_rd),
        .ex_rd1        (ex_rd1),
        .ex_rd2        (ex_rd2),
        .ex_imm        (ex_imm),
        .ex_pc4        (ex_pc4),
        .ex_valid      (ex_valid),
        .stall         (stall)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Does the decode instruction read register r?  Loads/I-type ALU only read rs.
    function automatic logic reads_reg(instr_t id, logic [AW-1:0] r);
        return (id.rs == r) || ((id.reg_dst || id.mem_write) && (id.rt == r));
    endfunction

    function automatic logic load_use(ex_t ex, instr_t id);
        return ex.f.mem_read && (ex.f.rt != 0) && reads_reg(id, ex.f.rt);
    endfunction

    function automatic instr_t mk(logic [5:0] c, logic [5:0] fn, logic [AW-1:0] rs,
                                  logic [AW-1:0] rt, logic [AW-1:0] rd,
                                  logic [DW-1:0] a, logic [DW-1:0] b);
        instr_t i;
        {i.reg_dst, i.reg_write, i.mem_read, i.mem_write, i.mem_to_reg, i.alu_src} = c;
        i.funct = fn;
        i.rs    = rs;
        i.rt    = rt;
        i.rd    = rd;
        i.rd1   = a;
        i.rd2   = b;
        i.imm   = $urandom;
        i.pc4   = $urandom;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        logic [5:0] c;
        c = 6'($urandom);
        return mk(c, 6'($urandom), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                  AW'($urandom_range(0, 31)), $urandom, $urandom);
    endfunction

    function automatic ex_t dut_ex();
        ex_t a;
        a.f.reg_dst    = ex_reg_dst;
        a.f.reg_write  = ex_reg_write;
        a.f.mem_read   = ex_mem_read;
        a.f.mem_write  = ex_mem_write;
        a.f.mem_to_reg = ex_mem_to_reg;
        a.f.alu_src    = ex_alu_src;
        a.f.funct      = ex_funct;
        a.f.rs         = ex_rs;
        a.f.rt         = ex_rt;
        a.f.rd         = ex_rd;
        a.f.rd1        = ex_rd1;
        a.f.rd2        = ex_rd2;
        a.f.imm        = ex_imm;
        a.f.pc4        = ex_pc4;
        a.valid        = ex_valid;
        return a;
    endfunction

    // Present one decode instruction for one cycle and record what EX must look like after it
    task automatic drive(input instr_t id, input logic fl);
        logic hz;
        logic st;
        ex_t  nx;
        {id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src} =
            {id.reg_dst, id.reg_write, id.mem_read, id.mem_write, id.mem_to_reg, id.alu_src};
        id_funct = id.funct;
        id_rs    = id.rs;
        id_rt    = id.rt;
        id_rd    = id.rd;
        id_rd1   = id.rd1;
        id_rd2   = id.rd2;
        id_imm   = id.imm;
        id_pc4   = id.pc4;
        flush    = fl;
        hz = load_use(m_ex, id);
        st = hz && !fl;
        q_stall.push_back(st);
        nx.f     = id;
        nx.valid = 1'b1;
        if (hz || fl) begin
            nx.f.reg_dst    = 1'b0;
            nx.f.reg_write  = 1'b0;
            nx.f.mem_read   = 1'b0;
            nx.f.mem_write  = 1'b0;
            nx.f.mem_to_reg = 1'b0;
            nx.f.alu_src    = 1'b0;
            nx.f.funct      = 6'd0;
            nx.valid        = 1'b0;
        end
        if (st && m_cnt < 32'd65535) m_cnt++;
        m_ex = nx;
        q_ex.push_back('{nx, 16'(m_cnt)});
        last_stall = st;
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle and check EX clears before any clock edge
    task automatic do_reset();
        ex_t a;
        mon_en = 1'b0;
        q_ex.delete();
        q_stall.delete();
        flush = 1'b0;
        {id_reg_dst, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src} = '0;
        id_funct = '0; id_rs = '0; id_rt = '0; id_rd = '0;
        id_rd2 = '0; id_imm = '0; id_pc4 = '0;
        id_reg_write = 1'b1;
        id_rd1 = 32'hDEADBEEF;
        #3;
        rst = 1'b1;
        #1;
        a = dut_ex();
        checks++;
        if (a !== '0) begin
            failures++;
            $display("FAIL reset_ex: got %h required 0", a);
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall: got %b required 0", stall);
        end
`ifdef ID_EX_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d required 0", stall_cnt);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ex = '0;
        m_cnt = 0;
        last_stall = 1'b0;
        q_ex.push_back('{ex_t'(0), 16'd0});
        mon_en = 1'b1;
    endtask

    // Monitor: stall is checked in the cycle it is driven, EX state one cycle after its push
    always @(negedge clk) begin
        if (mon_en) begin
            if (q_stall.size() > 0) begin
                logic es;
                es = q_stall.pop_front();
                checks++;
                if (stall !== es) begin
                    failures++;
                    $display("FAIL stall @%0t: got %b required %b", $time, stall, es);
                end
            end
            if (q_ex.size() >= 2) begin
                exp_t e;
                ex_t  a;
                e = q_ex.pop_front();
                a = dut_ex();
                checks++;
                if (a !== e.ex) begin
                    failures++;
                    $display("FAIL ex_state @%0t: got %h required %h", $time, a, e.ex);
                end
`ifdef ID_EX_STALL_CNT_EN
                checks++;
                if (stall_cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL stall_cnt @%0t: got %0d required %0d", $time, stall_cnt, e.cnt);
                end
`endif
            end
        end
    end

    initial begin
        instr_t cur;
        instr_t r9;
        instr_t sw9;
        instr_t lw10;
        do_reset();

        // Pass-through R-type
        drive(mk(CPass, 6'h20, 5'd8, 5'd9, 5'd10, 32'd5, 32'd7), 1'b0);
        // Load-use on rs: one stall, then the held instruction proceeds
        r9 = mk(CR, 6'h20, 5'd9, 5'd3, 5'd10, 32'd1, 32'd2);
        drive(mk(CLw, 6'd0, 5'd4, 5'd9, 5'd0, 32'd0, 32'd0), 1'b0);
        drive(r9, 1'b0);
        drive(r9, 1'b0);
        // addi reading only rs: rt match must not stall
        drive(mk(CLw, 6'd0, 5'd4, 5'd9, 5'd0, 32'd0, 32'd0), 1'b0);
        drive(mk(CAddi, 6'd0, 5'd4, 5'd9, 5'd0, 32'd3, 32'd4), 1'b0);
        // Store reads rt: stall
        sw9 = mk(CSw, 6'd0, 5'd4, 5'd9, 5'd0, 32'd5, 32'd6);
        drive(mk(CLw, 6'd0, 5'd4, 5'd9, 5'd0, 32'd0, 32'd0), 1'b0);
        drive(sw9, 1'b0);
        drive(sw9, 1'b0);
        // Load into $0 never stalls
        drive(mk(CLw, 6'd0, 5'd4, 5'd0, 5'd0, 32'd0, 32'd0), 1'b0);
        drive(mk(CR, 6'h20, 5'd0, 5'd0, 5'd10, 32'd0, 32'd0), 1'b0);
        // Flush with hazard: bubble, no stall, next instruction is a new one
        drive(mk(CLw, 6'd0, 5'd4, 5'd9, 5'd0, 32'd0, 32'd0), 1'b0);
        drive(r9, 1'b1);
        drive(mk(CR, 6'h22, 5'd2, 5'd3, 5'd4, 32'd8, 32'd9), 1'b0);
        // Back-to-back loads
        lw10 = mk(CLw, 6'd0, 5'd9, 5'd10, 5'd0, 32'd0, 32'd0);
        drive(mk(CLw, 6'd0, 5'd4, 5'd9, 5'd0, 32'd0, 32'd0), 1'b0);
        drive(lw10, 1'b0);
        drive(lw10, 1'b0);

        // Random traffic; a stalled instruction is re-presented as the upstream would
        cur = rand_instr();
        for (int i = 0; i < 300; i++) begin
            if (!last_stall) cur = rand_instr();
            drive(cur, ($urandom_range(0, 7) == 0));
        end

        do_reset();
        for (int i = 0; i < 200; i++) begin
            if (!last_stall) cur = rand_instr();
            drive(cur, ($urandom_range(0, 7) == 0));
        end
        drive(mk(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0), 1'b0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline, with the load-use hazard detector folded in.
- Captures the decode-stage control word (RegDst, RegWrite, MemRead, MemWrite, MemToReg, ALUSrc) and the operand/immediate data, and presents both to EX one cycle later.
- Generates the stall that freezes PC and IF/ID, and inserts bubbles on a load-use hazard or an upstream flush.

Parameters:
- DATA_W, 32, width of register operands, immediate and PC+4.
- REG_AW, 5, register-file address width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  squash the instruction entering EX (taken branch/jump resolved upstream).
- id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src  input  1 each  decode control bits.
- id_funct  input  6  function field for the EX ALU control.
- id_rs, id_rt, id_rd  input  REG_AW  register specifiers.
- id_rd1, id_rd2  input  DATA_W  register-file read data.
- id_imm  input  DATA_W  sign-extended immediate.
- id_pc4  input  DATA_W  PC+4 of the decode instruction.
- ex_reg_dst, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  output  1 each  registered controls.
- ex_funct  output  6  registered function field.
- ex_rs, ex_rt, ex_rd  output  REG_AW  registered specifiers.
- ex_rd1, ex_rd2, ex_imm, ex_pc4  output  DATA_W  registered data.
- ex_valid  output  1  1 = real instruction in EX, 0 = bubble.
- stall  output  1  combinational; 1 = hold PC and IF/ID this cycle.

Behaviour:
- Reset (async, rst=1): every registered output is 0 immediately, including ex_valid. stall is then 0, because ex_mem_read=0. Reset asserted mid-operation discards the EX contents with no partial update.
- Hazard detect (combinational):
  - hazard = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
  - uses_rt = id_reg_dst | id_mem_write (R-type and store read rt; I-type ALU and load do not).
  - stall = hazard & ~flush.
- Register update, each rising edge with rst=0:
  - If flush=1 or hazard=1, a bubble is loaded: all six ex controls 0, ex_funct 0, ex_valid 0.
  - In a bubble, data and specifier fields still load from the ID inputs. They are don't-care downstream but must be deterministic.
  - Otherwise all fields load from the ID inputs and ex_valid=1.
- Latency: exactly 1 cycle from ID inputs to EX outputs. No hold/enable of ID/EX itself; it updates every cycle.
- Stall is self-clearing:
  - The bubble has ex_mem_read=0, so the same decode instruction proceeds on the next cycle.
  - Maximum stall length is 1 cycle per load-use pair.
- Flush plus hazard in the same cycle: flush wins. A bubble is loaded, stall=0, and the squashed instruction is not re-presented.
- Back-to-back loads (lw $t1 then lw $t2,0($t1)): single 1-cycle stall, then the second load issues normally.
- rt=$0 as a load destination never raises a hazard.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (16 bits).
  - Increments on every rising edge where stall=1.
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst.
- When undefined: the port and the counter do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset: drive id_reg_write=1 and id_rd1=32'hDEADBEEF, assert rst mid-cycle -> all ex outputs and ex_valid go to 0 immediately, before any clock edge; stall=0.
- Pass-through: R-type with controls RegDst=1, RegWrite=1, MemToReg=1, rs=8, rt=9, rd=10, id_rd1=5, id_rd2=7 -> next edge: ex outputs match, ex_valid=1, stall stays 0.
- Load-use stall:
  - Stimulus: lw with rt=9 in EX (ex_mem_read=1), then ID holds R-type with rs=9.
  - Required: stall=1 for one cycle; the next edge loads a bubble (ex controls 0, ex_valid=0); the following cycle has stall=0 and the R-type enters EX.
- rt-use filter:
  - Stimulus: lw rt=9 in EX, ID holds addi with rt=9 and rs=4 (RegDst=0, MemWrite=0).
  - Required: stall=0, no bubble. Repeating with a store (MemWrite=1, rt=9) gives stall=1.
- Zero register: lw rt=0 in EX, ID R-type with rs=0 -> stall=0.
- Flush priority:
  - Stimulus: the load-use condition above plus flush=1 in the same cycle.
  - Required: stall=0, bubble loaded, ex_valid=0.
  - With ID_EX_STALL_CNT_EN defined, stall_cnt is unchanged on the flush case and increments by exactly 1 on the plain load-use case.
